// File: rtl/gray_to_rgb565_expander_pkg.sv
// Shared widths, RGB565 field layout and buffer-state encoding for the gray -> RGB565 expander.
package gray_rgb565_pkg;

  localparam int GRAY_W = 8;

  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

  localparam int R_W   = R_MSB - R_LSB + 1;
  localparam int G_W   = G_MSB - G_LSB + 1;
  localparam int B_W   = B_MSB - B_LSB + 1;
  localparam int RGB_W = R_W + G_W + B_W;

  localparam int PIX_PER_IN_WORD  = 4;
  localparam int PIX_PER_OUT_WORD = 2;
  localparam int IN_W             = GRAY_W * PIX_PER_IN_WORD;
  localparam int OUT_W            = RGB_W * PIX_PER_OUT_WORD;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LO    = 2'd1,
    ST_HI    = 2'd2
  } buf_state_e;

endpackage

// File: rtl/gray_to_rgb565_expander_if.sv
// Stream bundle between the grayscale reader, the expander and the display/DMA writer.
interface gray_to_rgb565_expander_if;
  import gray_rgb565_pkg::*;

  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

endinterface

// File: rtl/gray_to_rgb565_expander_pixel.sv
// Combinational 8-bit gray -> RGB565 replication.
// Build option GRAY2RGB_ROUND_EN selects round-to-nearest with saturation instead of truncation.
module gray_to_rgb565_pixel
  import gray_rgb565_pkg::*;
(
  input  logic [GRAY_W-1:0] gray,
  output logic [RGB_W-1:0]  rgb
);

`ifdef GRAY2RGB_ROUND_EN
  logic [GRAY_W:0] sum_rb;
  logic [GRAY_W:0] sum_g;
  logic [R_W-1:0]  rb5;
  logic [G_W-1:0]  g6;

  // The carry bit only rises for the top few codes, where the rounded value would overflow the field.
  always_comb begin
    sum_rb = {1'b0, gray} + (GRAY_W+1)'(4);
    sum_g  = {1'b0, gray} + (GRAY_W+1)'(2);
    rb5    = sum_rb[GRAY_W] ? '1 : sum_rb[GRAY_W-1 -: R_W];
    g6     = sum_g[GRAY_W]  ? '1 : sum_g[GRAY_W-1 -: G_W];
    rgb    = '0;
    rgb[R_MSB:R_LSB] = rb5;
    rgb[G_MSB:G_LSB] = g6;
    rgb[B_MSB:B_LSB] = rb5;
  end
`else
  always_comb begin
    rgb = '0;
    rgb[R_MSB:R_LSB] = gray[GRAY_W-1 -: R_W];
    rgb[G_MSB:G_LSB] = gray[GRAY_W-1 -: G_W];
    rgb[B_MSB:B_LSB] = gray[GRAY_W-1 -: B_W];
  end
`endif

endmodule

// File: rtl/gray_to_rgb565_expander.sv
// Streams 4 packed gray pixels per input word out as 2 words of 2 RGB565 pixels, with line-end marking.
//
// state    | meaning
// ST_EMPTY | no input word held; in_ready high
// ST_LO    | word held, bytes 0/1 not yet emitted
// ST_HI    | word held, bytes 2/3 not yet emitted; refill allowed when the output slot frees
module gray_to_rgb565_expander
  import gray_rgb565_pkg::*;
#(
  parameter int PIXELS_PER_LINE = 640
)
(
  input  logic                        clock,
  input  logic                        reset_n,
  gray_to_rgb565_expander_if.slave    bus
);

  localparam int WORDS_PER_LINE          = PIXELS_PER_LINE / PIX_PER_OUT_WORD;
  localparam int CNT_W                   = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WORDS_PER_LINE - 1);

  if (PIXELS_PER_LINE < PIX_PER_IN_WORD || (PIXELS_PER_LINE % PIX_PER_IN_WORD) != 0) begin : g_bad_cfg
    $error("PIXELS_PER_LINE must be a positive multiple of 4");
  end

  buf_state_e       state_q, state_d;
  logic [IN_W-1:0]  buf_q;
  logic [OUT_W-1:0] out_data_q;
  logic             out_valid_q;
  logic             out_last_q;
  logic [CNT_W-1:0] word_cnt_q;

  logic             slot_free;
  logic             phase;
  logic             load;
  logic             in_ready_c;
  logic             in_fire;
  logic [GRAY_W-1:0] gray_lo, gray_hi;
  logic [RGB_W-1:0]  rgb_lo, rgb_hi;

  always_comb begin
    slot_free  = !out_valid_q || bus.out_ready;
    phase      = (state_q == ST_HI);
    load       = (state_q != ST_EMPTY) && slot_free;
    // Refill in ST_HI coincides with the second-half load, so the buffer never stalls a busy stream.
    in_ready_c = reset_n && ((state_q == ST_EMPTY) || (phase && slot_free));
    in_fire    = bus.in_valid && in_ready_c;

    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: if (in_fire) state_d = ST_LO;
      ST_LO:    if (load)    state_d = ST_HI;
      ST_HI:    if (load)    state_d = in_fire ? ST_LO : ST_EMPTY;
      default:               state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= ST_EMPTY;
    else          state_q <= state_d;
  end

  always_comb begin
    gray_lo = phase ? buf_q[2*GRAY_W +: GRAY_W] : buf_q[0      +: GRAY_W];
    gray_hi = phase ? buf_q[3*GRAY_W +: GRAY_W] : buf_q[GRAY_W +: GRAY_W];
  end

  gray_to_rgb565_pixel u_pix_lo (.gray(gray_lo), .rgb(rgb_lo));
  gray_to_rgb565_pixel u_pix_hi (.gray(gray_hi), .rgb(rgb_hi));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      buf_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      if (in_fire) buf_q <= bus.in_data;
      if (load) begin
        out_data_q  <= {rgb_hi, rgb_lo};
        out_valid_q <= 1'b1;
        out_last_q  <= (word_cnt_q == CNT_LAST);
        word_cnt_q  <= (word_cnt_q == CNT_LAST) ? '0 : word_cnt_q + CNT_W'(1);
      end else if (slot_free) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;

endmodule
